// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the AXI SRAM slave:
//   - AXI response codes (OKAY / SLVERR)
//   - Read and write FSM state encodings
//   - Helper that turns a byte address into a byte offset from the memory base
// -----------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // Byte offset of a word-aligned address from the memory base. The two
    // low address bits are dropped because every beat is a full 32-bit word.
    // The subtraction wraps modulo 2^32, so addresses below the base come
    // out as huge offsets and fail the range check.
    function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        return {addr[31:2], 2'b00} - base;
    endfunction

endpackage

// File: rtl/sram_1r1w.sv
// -----------------------------------------------------------------------------
// sram_1r1w
// 32-bit wide, 2^DEPTH_LOG2 deep simple dual-port memory built from four
// byte-lane arrays so each lane maps onto block RAM with a plain write enable.
// Read is synchronous: o_rdata updates only on the edge where i_re is high and
// holds otherwise. A read and write to the same word on the same edge returns
// the old contents. No reset on storage or read register.
//
// Ports:
//   aclk     in   clock
//   i_re     in   read enable
//   i_raddr  in   read word index
//   o_rdata  out  registered read data
//   i_we     in   write enable
//   i_wbe    in   per-byte write enables
//   i_waddr  in   write word index
//   i_wdata  in   write data
// -----------------------------------------------------------------------------
module sram_1r1w #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  aclk,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [31:0]           o_rdata,
    input  logic                  i_we,
    input  logic [3:0]            i_wbe,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [31:0]           i_wdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_q;

            always_ff @(posedge aclk) begin
                if (i_we && i_wbe[gi]) begin
                    r_mem[i_waddr] <= i_wdata[gi*8 +: 8];
                end
                if (i_re) begin
                    r_q <= r_mem[i_raddr];
                end
            end

            assign o_rdata[gi*8 +: 8] = r_q;
        end
    endgenerate

endmodule

// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
// AXI slave backed by a 2^DEPTH_LOG2 x 32-bit SRAM at byte address ADDR_BASE.
// Independent read and write FSMs, one burst outstanding each. Every burst is
// treated as INCR with 32-bit beats; size, burst type and the two low address
// bits are ignored. Each beat is range-checked on its own and answers SLVERR
// when outside the memory. Write bursts end on wlast only.
//
// Ports:
//   aclk, reset                          clock, synchronous active-high reset
//   arid/araddr/arlen/arsize/arburst     read address channel
//   arvalid/arready
//   rid/rdata/rresp/rlast/rvalid/rready  read data channel
//   awid/awaddr/awlen/awsize/awburst     write address channel
//   awvalid/awready
//   wid/wdata/wstrb/wlast/wvalid/wready  write data channel
//   bid/bresp/bvalid/bready              write response channel
// -----------------------------------------------------------------------------
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter int          DEPTH_LOG2 = 10
) (
    input  logic        aclk,
    input  logic        reset,
    // AR
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    // R
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    // AW
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    // W
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // B
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    // ------------------------------------------------------------------
    // Read path state
    // ------------------------------------------------------------------
    rd_state_t             r_rd_state;
    rd_state_t             w_rd_state_next;
    logic [3:0]            r_rd_id;
    logic [31:0]           r_rd_addr;   // word-aligned byte address of current beat
    logic [8:0]            r_rd_cnt;    // beats still to deliver, including current
    logic                  r_rd_err;    // current beat was out of range
    logic [31:0]           w_rd_off;
    logic                  w_rd_in_range;
    logic [DEPTH_LOG2-1:0] w_rd_idx;
    logic                  w_sram_re;
    logic [31:0]           w_sram_rdata;

    // ------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------
    wr_state_t             r_wr_state;
    wr_state_t             w_wr_state_next;
    logic [3:0]            r_wr_id;
    logic [31:0]           r_wr_addr;
    logic                  r_wr_err;    // sticky: any beat of this burst out of range
    logic [31:0]           w_wr_off;
    logic                  w_wr_in_range;
    logic [DEPTH_LOG2-1:0] w_wr_idx;
    logic                  w_sram_we;

    // Inputs that carry no meaning for this slave.
    logic w_unused_ok;
    assign w_unused_ok = ^{arsize, arburst, awlen, awsize, awburst, wid,
                           araddr[1:0], awaddr[1:0]};

    // ------------------------------------------------------------------
    // Address decode (both paths)
    // ------------------------------------------------------------------
    assign w_rd_off      = word_offset(r_rd_addr, ADDR_BASE);
    assign w_rd_in_range = ((w_rd_off >> (DEPTH_LOG2 + 2)) == 32'd0);
    assign w_rd_idx      = w_rd_off[DEPTH_LOG2+1:2];

    assign w_wr_off      = word_offset(r_wr_addr, ADDR_BASE);
    assign w_wr_in_range = ((w_wr_off >> (DEPTH_LOG2 + 2)) == 32'd0);
    assign w_wr_idx      = w_wr_off[DEPTH_LOG2+1:2];

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_rd_state <= R_IDLE;
        end else begin
            r_rd_state <= w_rd_state_next;
        end
    end

    always_comb begin
        w_rd_state_next = r_rd_state;
        w_sram_re       = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (arvalid) begin
                    w_rd_state_next = R_FETCH;
                end
            end
            R_FETCH: begin
                // Skip the RAM access for out-of-range beats; data is forced
                // to zero on the way out anyway.
                w_sram_re       = w_rd_in_range;
                w_rd_state_next = R_DATA;
            end
            R_DATA: begin
                if (rready) begin
                    w_rd_state_next = (r_rd_cnt == 9'd1) ? R_IDLE : R_FETCH;
                end
            end
            default: begin
                w_rd_state_next = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_rd_id   <= '0;
            r_rd_addr <= '0;
            r_rd_cnt  <= '0;
            r_rd_err  <= 1'b0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (arvalid) begin
                        r_rd_id   <= arid;
                        r_rd_addr <= {araddr[31:2], 2'b00};
                        r_rd_cnt  <= {1'b0, arlen} + 9'd1;
                    end
                end
                R_FETCH: begin
                    r_rd_err <= !w_rd_in_range;
                end
                R_DATA: begin
                    if (rready) begin
                        r_rd_cnt  <= r_rd_cnt - 9'd1;
                        r_rd_addr <= r_rd_addr + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    // The RAM read register only moves on a fetch, so rdata stays stable for
    // as long as the beat is stalled in R_DATA.
    assign arready = (r_rd_state == R_IDLE);
    assign rvalid  = (r_rd_state == R_DATA);
    assign rid     = r_rd_id;
    assign rlast   = rvalid && (r_rd_cnt == 9'd1);
    assign rresp   = (rvalid && r_rd_err) ? RESP_SLVERR : RESP_OKAY;
    assign rdata   = (rvalid && !r_rd_err) ? w_sram_rdata : 32'd0;

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_wr_state <= W_IDLE;
        end else begin
            r_wr_state <= w_wr_state_next;
        end
    end

    always_comb begin
        w_wr_state_next = r_wr_state;
        w_sram_we       = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (awvalid) begin
                    w_wr_state_next = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    w_sram_we = w_wr_in_range;
                    if (wlast) begin
                        w_wr_state_next = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_wr_state_next = W_IDLE;
                end
            end
            default: begin
                w_wr_state_next = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_wr_id   <= '0;
            r_wr_addr <= '0;
            r_wr_err  <= 1'b0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (awvalid) begin
                        r_wr_id   <= awid;
                        r_wr_addr <= {awaddr[31:2], 2'b00};
                        r_wr_err  <= 1'b0;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        if (!w_wr_in_range) begin
                            r_wr_err <= 1'b1;
                        end
                        r_wr_addr <= r_wr_addr + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign awready = (r_wr_state == W_IDLE);
    assign wready  = (r_wr_state == W_DATA);
    assign bvalid  = (r_wr_state == W_RESP);
    assign bid     = r_wr_id;
    assign bresp   = (bvalid && r_wr_err) ? RESP_SLVERR : RESP_OKAY;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    sram_1r1w #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_sram (
        .aclk    (aclk),
        .i_re    (w_sram_re),
        .i_raddr (w_rd_idx),
        .o_rdata (w_sram_rdata),
        .i_we    (w_sram_we),
        .i_wbe   (wstrb),
        .i_waddr (w_wr_idx),
        .i_wdata (wdata)
    );

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;

    logic        aclk;
    logic        reset;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int checks   = 0;
    int failures = 0;

    localparam int WAIT_MAX = 50;

    axi_sram_slave #(
        .ADDR_BASE  (32'h0000_0000),
        .DEPTH_LOG2 (10)
    ) dut (
        .aclk    (aclk),
        .reset   (reset),
        .arid    (arid),
        .araddr  (araddr),
        .arlen   (arlen),
        .arsize  (arsize),
        .arburst (arburst),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready),
        .awid    (awid),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awsize  (awsize),
        .awburst (awburst),
        .awvalid (awvalid),
        .awready (awready),
        .wid     (wid),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bid     (bid),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n;
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arsize  = 3'd2;
        arburst = 2'b01;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < WAIT_MAX) begin step(); n++; end
        chk("ar_wait", {31'd0, arready}, 32'd1);
        step();
        arvalid = 1'b0;
        $display("AR id=%0d addr=%h len=%0d", id, addr, len);
    endtask

    task automatic rd_beat(input string tag, input logic [31:0] exp_d, input logic [1:0] exp_resp,
                           input logic [3:0] exp_id, input logic exp_last);
        int n;
        rready = 1'b1;
        n = 0;
        while (!rvalid && n < WAIT_MAX) begin step(); n++; end
        chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        chk({tag, "_rdata"}, rdata, exp_d);
        chk({tag, "_rresp"}, {30'd0, rresp}, {30'd0, exp_resp});
        chk({tag, "_rid"}, {28'd0, rid}, {28'd0, exp_id});
        chk({tag, "_rlast"}, {31'd0, rlast}, {31'd0, exp_last});
        $display("R %s id=%0d data=%h resp=%0d last=%0d", tag, rid, rdata, rresp, rlast);
        step();
    endtask

    task automatic wr_burst(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input int nbeats, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
        logic [31:0] d [4];
        int n;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        awid    = id;
        awaddr  = addr;
        awlen   = 8'(nbeats - 1);
        awsize  = 3'd2;
        awburst = 2'b01;
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < WAIT_MAX) begin step(); n++; end
        chk({tag, "_aw_wait"}, {31'd0, awready}, 32'd1);
        step();
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wdata  = d[i];
            wstrb  = strb;
            wlast  = (i == nbeats - 1);
            wvalid = 1'b1;
            n = 0;
            while (!wready && n < WAIT_MAX) begin step(); n++; end
            chk({tag, "_w_wait"}, {31'd0, wready}, 32'd1);
            step();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < WAIT_MAX) begin step(); n++; end
        chk({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
        chk({tag, "_bid"}, {28'd0, bid}, {28'd0, id});
        chk({tag, "_bresp"}, {30'd0, bresp}, {30'd0, exp_resp});
        $display("WR %s id=%0d addr=%h beats=%0d bresp=%0d", tag, bid, addr, nbeats, bresp);
        step();
        bready = 1'b0;
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready  = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        bready  = 1'b0;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_arready", {31'd0, arready}, 32'd1);
        chk("rst_awready", {31'd0, awready}, 32'd1);
        chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
        chk("rst_wready",  {31'd0, wready},  32'd0);
        chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
        chk("rst_rid",     {28'd0, rid},     32'd0);
        chk("rst_bid",     {28'd0, bid},     32'd0);
        chk("rst_rresp",   {30'd0, rresp},   32'd0);
        chk("rst_bresp",   {30'd0, bresp},   32'd0);
        chk("rst_rlast",   {31'd0, rlast},   32'd0);
        chk("rst_rdata",   rdata,            32'd0);
        $display("RESET checked");
        reset = 1'b0;
        step();

        // W beats before AW must not be taken
        wvalid = 1'b1; wdata = 32'h0BAD_0BAD; wstrb = 4'hF; wlast = 1'b1;
        step();
        chk("w_early_wready0", {31'd0, wready}, 32'd0);
        step();
        chk("w_early_wready1", {31'd0, wready}, 32'd0);
        wvalid = 1'b0; wlast = 1'b0;
        $display("W-before-AW held off");

        // Single write then read, with first-beat latency
        wr_burst("single", 4'd3, 32'h10, 1, 32'hDEADBEEF, 0, 0, 0, 4'hF, 2'b00);
        ar_send(4'd5, 32'h10, 8'd0);
        chk("lat_fetch_rvalid", {31'd0, rvalid}, 32'd0);
        step();
        chk("lat_data_rvalid", {31'd0, rvalid}, 32'd1);
        rd_beat("single", 32'hDEADBEEF, 2'b00, 4'd5, 1'b1);
        chk("single_idle_arready", {31'd0, arready}, 32'd1);

        // Burst with stall on beat 2
        wr_burst("burst", 4'd1, 32'h40, 4, 32'd1, 32'd2, 32'd3, 32'd4, 4'hF, 2'b00);
        ar_send(4'd6, 32'h40, 8'd3);
        rd_beat("burst_b1", 32'd1, 2'b00, 4'd6, 1'b0);
        rready = 1'b0;
        n = 0;
        while (!rvalid && n < WAIT_MAX) begin step(); n++; end
        chk("burst_b2_rvalid", {31'd0, rvalid}, 32'd1);
        chk("burst_b2_rdata", rdata, 32'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_rvalid", {31'd0, rvalid}, 32'd1);
            chk("stall_rdata", rdata, 32'd2);
            chk("stall_rlast", {31'd0, rlast}, 32'd0);
            chk("stall_rid", {28'd0, rid}, 32'd6);
        end
        $display("R burst_b2 stalled 3 cycles data=%h", rdata);
        rready = 1'b1;
        step();
        rd_beat("burst_b3", 32'd3, 2'b00, 4'd6, 1'b0);
        rd_beat("burst_b4", 32'd4, 2'b00, 4'd6, 1'b1);

        // Byte strobes
        wr_burst("strb_full", 4'd2, 32'h20, 1, 32'h11223344, 0, 0, 0, 4'hF, 2'b00);
        wr_burst("strb_part", 4'd2, 32'h20, 1, 32'hAABBCCDD, 0, 0, 0, 4'b0101, 2'b00);
        ar_send(4'd2, 32'h20, 8'd0);
        rd_beat("strb", 32'h11BB33DD, 2'b00, 4'd2, 1'b1);

        // Range edge
        wr_burst("edge_last", 4'd4, 32'hFFC, 1, 32'hCAFEF00D, 0, 0, 0, 4'hF, 2'b00);
        ar_send(4'd8, 32'hFFC, 8'd1);
        rd_beat("edge_b0", 32'hCAFEF00D, 2'b00, 4'd8, 1'b0);
        rd_beat("edge_b1", 32'd0, 2'b10, 4'd8, 1'b1);
        wr_burst("word0", 4'd4, 32'h0, 1, 32'h01234567, 0, 0, 0, 4'hF, 2'b00);
        wr_burst("oor", 4'd11, 32'h1000, 1, 32'hBADBAD00, 0, 0, 0, 4'hF, 2'b10);
        ar_send(4'd1, 32'h0, 8'd0);
        rd_beat("oor_word0", 32'h01234567, 2'b00, 4'd1, 1'b1);
        ar_send(4'd1, 32'hFFC, 8'd0);
        rd_beat("oor_wordlast", 32'hCAFEF00D, 2'b00, 4'd1, 1'b1);

        // AR and AW in the same cycle
        arid = 4'd7; araddr = 32'h10; arlen = 8'd0; arvalid = 1'b1;
        awid = 4'd9; awaddr = 32'h80; awlen = 8'd0; awvalid = 1'b1;
        chk("conc_arready", {31'd0, arready}, 32'd1);
        chk("conc_awready", {31'd0, awready}, 32'd1);
        step();
        arvalid = 1'b0; awvalid = 1'b0;
        chk("conc_ar_taken", {31'd0, arready}, 32'd0);
        chk("conc_aw_taken", {31'd0, awready}, 32'd0);
        chk("conc_wready", {31'd0, wready}, 32'd1);
        $display("AR+AW same-cycle handshake");
        rd_beat("conc", 32'hDEADBEEF, 2'b00, 4'd7, 1'b1);
        wdata = 32'h5555AAAA; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        step();
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < WAIT_MAX) begin step(); n++; end
        chk("conc_bvalid", {31'd0, bvalid}, 32'd1);
        chk("conc_bid", {28'd0, bid}, 32'd9);
        chk("conc_bresp", {30'd0, bresp}, 32'd0);
        $display("B conc id=%0d resp=%0d", bid, bresp);
        step();
        bready = 1'b0;
        ar_send(4'd3, 32'h80, 8'd0);
        rd_beat("conc_rb", 32'h5555AAAA, 2'b00, 4'd3, 1'b1);

        // Reset during beat 2 of a 4-beat read
        ar_send(4'd12, 32'h40, 8'd3);
        rd_beat("rst_b1", 32'd1, 2'b00, 4'd12, 1'b0);
        rready = 1'b0;
        n = 0;
        while (!rvalid && n < WAIT_MAX) begin step(); n++; end
        chk("rst_b2_rdata", rdata, 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("midrst_arready", {31'd0, arready}, 32'd1);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_rid", {28'd0, rid}, 32'd0);
        rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst_no_beats", {31'd0, rvalid}, 32'd0);
        end
        $display("RESET mid-burst aborted read");
        ar_send(4'd13, 32'h44, 8'd1);
        rd_beat("post_rst_b0", 32'd2, 2'b00, 4'd13, 1'b0);
        rd_beat("post_rst_b1", 32'd3, 2'b00, 4'd13, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 The block SHALL take parameter ADDR_BASE, default 32'h0000_0000, as the byte address of memory word 0.
REQ-002 The block SHALL take parameter DEPTH_LOG2, default 10, giving a memory of 2^DEPTH_LOG2 32-bit words.
REQ-003 Clock and reset SHALL be: aclk input 1 (clock); reset input 1 (synchronous, active-high).
REQ-004 The AR channel SHALL be: arid in 4, araddr in 32, arlen in 8, arsize in 3, arburst in 2, arvalid in 1, arready out 1.
REQ-005 The R channel SHALL be: rid out 4, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1.
REQ-006 The AW channel SHALL be: awid in 4, awaddr in 32, awlen in 8, awsize in 3, awburst in 2, awvalid in 1, awready out 1.
REQ-007 The W channel SHALL be: wid in 4, wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1.
REQ-008 The B channel SHALL be: bid out 4, bresp out 2, bvalid out 1, bready in 1.

Function
REQ-009 Read and write paths SHALL be independent FSMs, each with at most one burst outstanding; no reordering, no interleaving.
REQ-010 Read FSM SHALL use states R_IDLE, R_FETCH, R_DATA; arready = (state==R_IDLE).
REQ-011 On the AR handshake, the FSM SHALL latch arid, word address, and beat count arlen+1, then go R_IDLE->R_FETCH.
REQ-012 R_FETCH SHALL issue one synchronous SRAM read and then go to R_DATA; minimum latency from AR handshake to first rvalid SHALL be 2 cycles, with each further beat 2 cycles.
REQ-013 In R_DATA, rvalid SHALL be 1 and rdata/rresp/rid/rlast SHALL be held stable until rready; rlast = (remaining beats == 1).
REQ-014 On an R handshake, the FSM SHALL go to R_IDLE if rlast, else to R_FETCH with the word address incremented by 1.
REQ-015 Word index SHALL be (addr-ADDR_BASE)>>2; an index >= 2^DEPTH_LOG2 (unsigned) SHALL be out of range.
REQ-016 Each beat SHALL be checked independently; an out-of-range read beat SHALL return rresp=2'b10 (SLVERR) and rdata=0, and an in-range beat SHALL return rresp=2'b00.
REQ-017 All bursts SHALL be treated as INCR regardless of arburst/awburst; arsize/awsize SHALL be ignored (32-bit beats); araddr[1:0]/awaddr[1:0] SHALL be ignored.
REQ-018 Write FSM SHALL use states W_IDLE, W_DATA, W_RESP; awready = (state==W_IDLE), wready = (state==W_DATA), bvalid = (state==W_RESP).
REQ-019 On the AW handshake, the FSM SHALL latch awid and word address, clear the error flag, and go to W_DATA; W beats presented before the AW handshake SHALL NOT be accepted.
REQ-020 Each W handshake SHALL write the bytes enabled by wstrb at the current word address, one cycle after the handshake at the latest, then increment the address.
REQ-021 An out-of-range write beat SHALL leave memory unchanged and set the error flag.
REQ-022 Burst end SHALL be defined by wlast only; awlen SHALL NOT terminate or truncate the burst, and wid SHALL be ignored.
REQ-023 On the wlast handshake, the FSM SHALL go to W_RESP with bid = latched awid and bresp = error flag ? 2'b10 : 2'b00, held until bready, then return to W_IDLE.
REQ-024 Same-cycle SRAM read and write to the same word SHALL return the old data (read-before-write); a read issued in any later cycle SHALL see the new data.
REQ-025 Address increment SHALL wrap modulo 2^32 on the byte address; a wrapped beat SHALL then follow the REQ-015/016 range check.
REQ-026 AR and AW handshakes in the same cycle SHALL both be accepted.

Reset
REQ-027 While reset=1 on an aclk edge, both FSMs SHALL enter IDLE; arready=1, awready=1, rvalid=0, wready=0, bvalid=0, rid/bid/rresp/bresp/rlast/rdata=0.
REQ-028 Reset mid-burst SHALL abort the burst with no further beats or response; memory contents SHALL NOT be cleared, and words already written SHALL persist.

Structure
REQ-029 The AXI response codes (OKAY=2'b00, SLVERR=2'b10) and FSM state encodings SHALL live in the shared package axi_pkg.
REQ-030 Storage SHALL be one sub-module, sram_1r1w: one synchronous read port and one byte-enable write port, 32-bit wide, 2^DEPTH_LOG2 deep, no reset.

Verification
REQ-031 Single write then read: AW addr 0x10 len 0 id 3, W 0xDEADBEEF strb 4'hF -> B id 3 OKAY; then AR 0x10 len 0 id 5 -> R 0xDEADBEEF, rlast=1, id 5, OKAY.
REQ-032 Burst: write 4 beats at 0x40 (1,2,3,4); read AR 0x40 len 3 with rready low for 3 cycles on beat 2 -> beats 1,2,3,4 with beat 2 stable while stalled, rlast only on beat 4.
REQ-033 Byte strobes: after 0x11223344 at 0x20, write 0xAABBCCDD strb 4'b0101 -> readback 0x11BB33DD.
REQ-034 Range edge (DEPTH_LOG2=10): AR at 0xFFC len 1 -> beat 0 OKAY with data, beat 1 SLVERR with rdata 0; write at 0x1000 -> bresp SLVERR, memory unchanged.
REQ-035 Concurrency/reset: AR and AW asserted in the same cycle -> both handshake that cycle; reset asserted during beat 2 of a 4-beat read -> rvalid=0 next cycle, arready=1, new read returns correct data.
